// File: rtl/inv_shiftrows_if.sv
// Byte-stream bus for the AES InvShiftRows block. There is no backpressure.
// inValid qualifies inBits on a rising edge, and ready qualifies outBits in the same cycle.
interface inv_shiftrows_if;
  logic       inValid;
  logic [7:0] inBits;
  logic [7:0] outBits;
  logic       ready;

  modport master (output inValid, output inBits, input outBits, input ready);
  modport slave  (input inValid, input inBits, output outBits, output ready);
endinterface

// File: rtl/inv_shiftrows.sv
// AES InvShiftRows on a byte stream. Two 16-byte banks work in ping-pong:
// one bank fills while the other is read out in permuted order.
module inv_shiftrows (
  input  logic            clk,
  input  logic            rst,
  inv_shiftrows_if.slave  bus,
  output logic            dbg_state
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wcnt;
  logic [3:0] rcnt;
  logic       wsel;
  logic [7:0] mem [32];
  logic       last_in;
  logic [1:0] row;
  logic [1:0] col;
  logic [1:0] src_col;
  logic [3:0] src;
  logic [7:0] out_d;
  logic       rdy_d;

  assign last_in = bus.inValid && (wcnt == 4'd15);

  // Output index r + 4c takes its byte from column (c - r) mod 4 of the same row.
  assign row     = rcnt[1:0];
  assign col     = rcnt[3:2];
  assign src_col = col - row;
  assign src     = {src_col, row};

  assign dbg_state = state;

  // Write side. The edge that stores byte 15 also hands the bank over to the reader.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= 4'd0;
      wsel <= 1'b0;
    end else if (bus.inValid) begin
      wcnt <= wcnt + 4'd1;
      if (last_in) wsel <= ~wsel;
    end
  end

  // Bank storage is never cleared. A partial block is orphaned because wcnt resets.
  always_ff @(posedge clk) begin
    if (!rst && bus.inValid) mem[{wsel, wcnt}] <= bus.inBits;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      if (last_in)           rcnt <= 4'd0;
      else if (state == EMIT) rcnt <= rcnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (last_in) state_nxt = EMIT;
      EMIT:    if ((rcnt == 4'd15) && !last_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The read bank is the one that is not being written.
  always_comb begin
    out_d = 8'h00;
    rdy_d = 1'b0;
    if (state == EMIT) begin
      out_d = mem[{~wsel, src}];
      rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.outBits <= 8'h00;
      bus.ready   <= 1'b0;
    end else begin
      bus.outBits <= out_d;
      bus.ready   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_inv_shiftrows.sv
// Self-checking bench for inv_shiftrows. A block-level InvShiftRows model feeds
// a cycle-accurate expected queue that is compared against the DUT on every negedge.
module tb_inv_shiftrows;

  logic clk;
  logic rst;
  logic dbg_state;
  int   checks;
  int   failures;

  logic [7:0] exp_q [$];
  logic [7:0] staged [$];
  logic [7:0] blk [$];

  inv_shiftrows_if bus ();

  inv_shiftrows dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Each step first checks what the previous edge produced, then drives the next edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    logic       e_rdy;
    logic [7:0] e_out;
    logic       e_state;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e_rdy = 1'b1;
      e_out = exp_q.pop_front();
    end else begin
      e_rdy = 1'b0;
      e_out = 8'h00;
    end
    checks++;
    assert (bus.ready === e_rdy) else begin
      failures++;
      $error("FAIL ready observed=%0b expected=%0b t=%0t", bus.ready, e_rdy, $time);
    end
    checks++;
    assert (bus.outBits === e_out) else begin
      failures++;
      $error("FAIL outBits observed=%02h expected=%02h t=%0t", bus.outBits, e_out, $time);
    end
    while (staged.size() != 0) exp_q.push_back(staged.pop_front());
    e_state = (exp_q.size() != 0);
    checks++;
    assert (dbg_state === e_state) else begin
      failures++;
      $error("FAIL state observed=%0b expected=%0b t=%0t", dbg_state, e_state, $time);
    end
    rst         = r;
    bus.inValid = v;
    bus.inBits  = d;
    if (r) begin
      blk.delete();
      staged.delete();
      exp_q.delete();
    end else if (v) begin
      blk.push_back(d);
      if (blk.size() == 16) begin
        for (int k = 0; k < 16; k++) begin
          int rr;
          int cc;
          rr = k % 4;
          cc = k / 4;
          staged.push_back(blk[rr + 4 * ((cc - rr + 4) % 4)]);
        end
        blk.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_block(input logic [7:0] base);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, base + 8'(i));
  endtask

  logic [7:0] fwd [16];

  initial begin
    checks      = 0;
    failures    = 0;
    fwd = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
            8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    rst         = 1'b1;
    bus.inValid = 1'b0;
    bus.inBits  = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state, then basic block 00..0F.
    idle(3);
    send_block(8'h00);
    idle(20);

    // Forward ShiftRows output round-trips to 00..0F.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, fwd[i]);
    idle(20);

    // Gaps inside a block.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i));
      if (i == 3 || i == 7 || i == 14) idle(2);
    end
    idle(20);

    // Back-to-back blocks stream without a bubble.
    send_block(8'h00);
    send_block(8'h10);
    idle(20);

    // Reset mid-emit drops the remaining bytes of that block and the partial next block.
    send_block(8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom));
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom));
    step(1'b1, 1'b0, 8'h00);
    send_block(8'h00);
    idle(20);

    // Long idle with toggling data.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 8'hFF : 8'h00);

    // Random blocks with random gaps and occasional back-to-back streaming.
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 16; i++) begin
        step(1'b0, 1'b1, 8'($urandom));
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      idle($urandom_range(0, 18));
    end

    // Random reset while emitting.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'($urandom));
    idle($urandom_range(1, 14));
    step(1'b1, 1'b0, 8'h00);
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
